// File: rtl/addon_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding and the default operand width so that the
// adder core, its bus interface and any neighbouring blocks agree on them.
package addon_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_seq_if.sv
// Request/result bundle for serial_add_seq.
//   ena        : clock enable, low freezes the adder
//   start      : request an addition of op_a + op_b
//   op_a, op_b : operands, sampled when start is accepted
//   busy       : addition in progress
//   done       : one-cycle pulse, sum/carry_out valid
//   sum        : result bits, held until the next accepted start
//   carry_out  : carry out of the MSB, held with sum
// master = requester side, slave = adder side.
interface serial_add_seq_if #(
    parameter int WIDTH = addon_pkg::WIDTH_DEFAULT
);
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output ena, start, op_a, op_b,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  ena, start, op_a, op_b,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/half_add_cell.sv
// Purely combinational half adder, the building block of the serial
// full adder.
//   a, b : input bits
//   s    : a ^ b
//   c    : a & b
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one result bit per enabled clock, LSB first.
// An accepted start loads both operands; WIDTH SHIFT cycles later the FSM
// spends one cycle in DONE (done=1) and returns to IDLE.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_seq_if slave modport (ena/start/operands in,
//           busy/done/sum/carry_out out)
module serial_add_seq
    import addon_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Full adder on the current LSBs: two half adders plus an OR of carries.
    logic s_ab, c_ab, fa_s, c_sc, fa_c;

    half_add_cell u_ha_ab (
        .a (a_reg[0]),
        .b (b_reg[0]),
        .s (s_ab),
        .c (c_ab)
    );

    half_add_cell u_ha_sc (
        .a (s_ab),
        .b (carry_reg),
        .s (fa_s),
        .c (c_sc)
    );

    assign fa_c = c_ab | c_sc;

    // All state is gated by ena so a stall resumes exactly where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (bus.ena) begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                // sum/carry_out are left untouched here: they hold the
                // previous result until the new one starts shifting in.
                if (bus.start) begin
                    a_next     = bus.op_a;
                    b_next     = bus.op_b;
                    carry_next = 1'b0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                sum_next   = {fa_s, sum_reg[WIDTH-1:1]};
                carry_next = fa_c;
                // carry_out tracks the running carry; after the last bit it
                // is the carry out of the MSB.
                cout_next  = fa_c;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_reg == SHIFT);
    assign bus.done      = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.carry_out = cout_reg;

endmodule
